// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the sequential ALU.
// Optional multiply/divide support is enabled by defining ALU_MULDIV_EN.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6;
  localparam logic [3:0] ALU_SLTU = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SLL  = 4'h9;
  localparam logic [3:0] ALU_SRA  = 4'hA;
  localparam logic [3:0] ALU_MULT = 4'hB;
  localparam logic [3:0] ALU_MULTU = 4'hC;
  localparam logic [3:0] ALU_DIV  = 4'hD;
  localparam logic [3:0] ALU_DIVU = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_muldiv(logic [3:0] op);
    return (op >= ALU_MULT) && (op <= ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Valid/ready request and response bundle for the sequential ALU.
// Master drives operands and out_ready; slave returns results.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, a, b, alu_control, shamt, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, overflow
  );

  modport slave (
    input  in_valid, a, b, alu_control, shamt, out_ready,
    output in_ready, out_valid, result, result_hi, zero, overflow
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider on one shared adder.
// Built only when ALU_MULDIV_EN is defined; start loads, done pulses.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_q;
  logic               is_mul;
  logic               neg_lo;
  logic               neg_hi;
  logic               dbz;
  logic               ovf_q;

  logic             sgn_op;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             mul_op;

  assign sgn_op = (op == ALU_MULT) || (op == ALU_DIV);
  assign sa     = sgn_op & a[WIDTH-1];
  assign sb     = sgn_op & b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;
  assign mul_op = (op == ALU_MULT) || (op == ALU_MULTU);

  logic [WIDTH:0] add_x;
  logic [WIDTH:0] add_y;
  logic [WIDTH:0] sum;

  // Multiply adds into the high half; divide subtracts the shifted remainder.
  assign add_x = is_mul ? {1'b0, acc[2*WIDTH-1:WIDTH]}
                        : acc[2*WIDTH-1:WIDTH-1];
  assign add_y = is_mul ? {1'b0, opnd} : ~{1'b0, opnd};
  assign sum   = add_x + add_y + {{WIDTH{1'b0}}, ~is_mul};

  always_comb begin
    acc_nxt = acc;
    if (is_mul) begin
      acc_nxt = acc[0] ? {sum, acc[WIDTH-1:1]}
                       : {1'b0, acc[2*WIDTH-1:1]};
    end else if (!sum[WIDTH]) begin
      acc_nxt = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign prod = neg_lo ? -acc_nxt : acc_nxt;
  assign quo  = acc_nxt[WIDTH-1:0];
  assign rem  = acc_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    lo = prod[WIDTH-1:0];
    hi = prod[2*WIDTH-1:WIDTH];
    if (!is_mul) begin
      lo = dbz ? '1 : (neg_lo ? -quo : quo);
      hi = dbz ? a_q : (neg_hi ? -rem : rem);
    end
  end

  assign done = busy && (cnt == '0);
  assign ovf  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_q    <= '0;
      is_mul <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dbz    <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(WIDTH - 1);
      acc    <= {{WIDTH{1'b0}}, mul_op ? mag_b : mag_a};
      opnd   <= mul_op ? mag_a : mag_b;
      a_q    <= a;
      is_mul <= mul_op;
      neg_lo <= sa ^ sb;
      neg_hi <= sa;
      dbz    <= !mul_op && (b == '0);
      ovf_q  <= (op == ALU_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}})
                && (b == '1);
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle ops plus iterative mul/div.
// Mul/div codes are live only when ALU_MULDIV_EN is defined.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   io
);
  alu_state_t       state;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             overflow;

  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] dif_ab;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             md_op;

  assign sum_ab  = io.a + io.b;
  assign dif_ab  = io.a - io.b;
  assign add_ovf = (io.a[WIDTH-1] == io.b[WIDTH-1])
                   && (sum_ab[WIDTH-1] != io.a[WIDTH-1]);
  assign sub_ovf = (io.a[WIDTH-1] != io.b[WIDTH-1])
                   && (dif_ab[WIDTH-1] != io.a[WIDTH-1]);

  always_comb begin
    sc_res = sum_ab;
    sc_ovf = add_ovf;
    unique case (1'b1)
      io.alu_control == ALU_SUB: begin
        sc_res = dif_ab;
        sc_ovf = sub_ovf;
      end
      io.alu_control == ALU_AND: begin
        sc_res = io.a & io.b;
        sc_ovf = 1'b0;
      end
      io.alu_control == ALU_OR: begin
        sc_res = io.a | io.b;
        sc_ovf = 1'b0;
      end
      io.alu_control == ALU_XOR: begin
        sc_res = io.a ^ io.b;
        sc_ovf = 1'b0;
      end
      io.alu_control == ALU_NOR: begin
        sc_res = ~(io.a | io.b);
        sc_ovf = 1'b0;
      end
      io.alu_control == ALU_SLT: begin
        sc_res = {{(WIDTH-1){1'b0}}, $signed(io.a) < $signed(io.b)};
        sc_ovf = 1'b0;
      end
      io.alu_control == ALU_SLTU: begin
        sc_res = {{(WIDTH-1){1'b0}}, io.a < io.b};
        sc_ovf = 1'b0;
      end
      io.alu_control == ALU_SRL: begin
        sc_res = io.b >> io.shamt;
        sc_ovf = 1'b0;
      end
      io.alu_control == ALU_SLL: begin
        sc_res = io.b << io.shamt;
        sc_ovf = 1'b0;
      end
      io.alu_control == ALU_SRA: begin
        sc_res = $signed(io.b) >>> io.shamt;
        sc_ovf = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic             md_ovf;

  assign md_op = is_muldiv(io.alu_control);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (io.in_valid && (state == ST_IDLE) && md_op),
    .op    (io.alu_control),
    .a     (io.a),
    .b     (io.b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi),
    .ovf   (md_ovf)
  );
`else
  assign md_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.in_valid) begin
            if (md_op) begin
              state <= ST_BUSY;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= sc_res;
              result_hi <= '0;
              zero      <= (sc_res == '0);
              overflow  <= sc_ovf;
            end
          end
        end
`ifdef ALU_MULDIV_EN
        ST_BUSY: begin
          if (md_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= md_lo;
            result_hi <= md_hi;
            zero      <= (md_lo == '0);
            overflow  <= md_ovf;
          end
        end
`endif
        ST_DONE: begin
          if (io.out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == ST_IDLE);
  assign io.out_valid = out_valid;
  assign io.result    = result;
  assign io.result_hi = result_hi;
  assign io.zero      = zero;
  assign io.overflow  = overflow;

endmodule
